// File: rtl/eth_rx_pkg.sv
// Shared constants, types and the CRC-32 byte step for the Ethernet receive FCS checker.
// The optional length checks in eth_rx_crc_chk are enabled by the macro ETH_RX_LEN_CHK_EN.
package eth_rx_pkg;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam int          MIN_LEN     = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    typedef struct packed {
        logic        crc_ok;
        logic        runt;
        logic        giant;
        logic        seq_err;
        logic [11:0] rsvd;
        logic [15:0] byte_cnt;
    } stat_word_t;

    // Reflected CRC-32, LSB first; the register is not inverted on output.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_crc_chk_if.sv
// Receive beat stream and status FIFO read port of eth_rx_crc_chk, plus FSM state for observation.
// No backpressure: every rx_vld beat is consumed; stat_pull pops the head only while !stat_empty.
interface eth_rx_crc_chk_if #(
    parameter int DW = 32
) ();
    logic                  rx_vld;
    logic [63:0]           rx_data;
    logic                  rx_sof;
    logic                  rx_eof;
    logic [7:0]            rx_bvalid;
    logic                  stat_pull;
    logic [DW-1:0]         stat_dataout;
    logic                  stat_empty;
    logic                  stat_full;
    logic                  stat_ovf;
    eth_rx_pkg::state_t    dbg_state;

    modport master (
        output rx_vld, rx_data, rx_sof, rx_eof, rx_bvalid, stat_pull,
        input  stat_dataout, stat_empty, stat_full, stat_ovf, dbg_state
    );

    modport slave (
        input  rx_vld, rx_data, rx_sof, rx_eof, rx_bvalid, stat_pull,
        output stat_dataout, stat_empty, stat_full, stat_ovf, dbg_state
    );
endinterface

// File: rtl/eth_rx_stat_fifo.sv
// Show-ahead status FIFO, depth 2**AW, with a sticky overflow flag for dropped pushes.
module eth_rx_stat_fifo #(
    parameter int AW = 2,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pull,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          ovf
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pull;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pull on a full FIFO frees the slot the same-cycle push lands in.
    assign do_pull = pull && !empty;
    assign do_push = push && (!full || do_pull);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pull) rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_push) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/eth_rx_crc_chk.sv
// Ethernet receive FCS checker: per-frame CRC-32 residue check, byte count and status FIFO.
// Define ETH_RX_LEN_CHK_EN to compute the runt/giant status bits; otherwise they read 0.
module eth_rx_crc_chk
    import eth_rx_pkg::*;
#(
    parameter int AW     = 2,
    parameter int DW     = 32,
    parameter int MAXLEN = 1518
) (
    input  logic             clk,
    input  logic             rst_n,
    eth_rx_crc_chk_if.slave  rx
);

    state_t      state_q, state_d;
    logic [31:0] crc_q;
    logic [15:0] cnt_q;
    logic [31:0] crc_acc;
    logic [15:0] cnt_base;
    logic [16:0] cnt_sum;
    logic [15:0] cnt_nxt;
    logic [3:0]  n_bytes;
    logic        contig;
    logic        crc_ok;
    logic        load;
    logic        push_d, push_q;
    stat_word_t  word_d, word_q;

    logic [DW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_ovf;

    function automatic stat_word_t mk_word(input logic ok, input logic seq, input logic [15:0] cnt);
        stat_word_t w;
        w          = '0;
        w.crc_ok   = ok;
        w.seq_err  = seq;
        w.byte_cnt = cnt;
`ifdef ETH_RX_LEN_CHK_EN
        w.runt     = (cnt < 16'(MIN_LEN));
        w.giant    = ({16'h0, cnt} > 32'(MAXLEN));
`endif
        return w;
    endfunction

    // Beat datapath: a sof beat restarts the CRC and count regardless of state.
    always_comb begin
        crc_acc  = rx.rx_sof ? CRC_INIT : crc_q;
        cnt_base = rx.rx_sof ? 16'h0 : cnt_q;
        n_bytes  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (rx.rx_bvalid[i]) begin
                crc_acc = crc32_byte(crc_acc, rx.rx_data[8*i +: 8]);
                n_bytes = n_bytes + 4'd1;
            end
        end
        cnt_sum = {1'b0, cnt_base} + {13'h0, n_bytes};
        cnt_nxt = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        contig  = ((rx.rx_bvalid & (rx.rx_bvalid + 8'd1)) == 8'd0);
        crc_ok  = (crc_acc == CRC_RESIDUE);
    end

    // A sof+eof beat that interrupts an open frame reports only the interrupted frame.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        push_d  = 1'b0;
        word_d  = '0;
        case (state_q)
            IDLE: begin
                if (rx.rx_vld && rx.rx_sof) begin
                    load = 1'b1;
                    if (rx.rx_eof) begin
                        push_d = 1'b1;
                        word_d = mk_word(crc_ok, !contig, cnt_nxt);
                    end else begin
                        state_d = FRAME;
                    end
                end
            end
            FRAME: begin
                if (rx.rx_vld) begin
                    load = 1'b1;
                    if (rx.rx_sof) begin
                        push_d  = 1'b1;
                        word_d  = mk_word(1'b0, 1'b1, cnt_q);
                        state_d = rx.rx_eof ? IDLE : FRAME;
                    end else if (rx.rx_eof) begin
                        push_d  = 1'b1;
                        word_d  = mk_word(crc_ok, !contig, cnt_nxt);
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            crc_q   <= CRC_INIT;
            cnt_q   <= 16'h0;
            push_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            push_q  <= push_d;
            word_q  <= word_d;
            if (load) begin
                crc_q <= crc_acc;
                cnt_q <= cnt_nxt;
            end
        end
    end

    eth_rx_stat_fifo #(
        .AW (AW),
        .DW (DW)
    ) u_stat_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .din   (DW'(word_q)),
        .pull  (rx.stat_pull),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .ovf   (fifo_ovf)
    );

    assign rx.stat_dataout = fifo_dout;
    assign rx.stat_full    = fifo_full;
    assign rx.stat_empty   = fifo_empty;
    assign rx.stat_ovf     = fifo_ovf;
    assign rx.dbg_state    = state_q;

endmodule

// File: doc/eth_rx_crc_chk.md
ETH_RX_CRC_CHK -- requirements
Module: eth_rx_crc_chk

Interface
REQ-001 SHALL have parameter AW, default 2, meaning status FIFO address width (depth 2**AW).
REQ-002 SHALL have parameter DW, default 32, meaning status word width (fixed layout, see REQ-013).
REQ-003 SHALL have parameter MAXLEN, default 1518, meaning giant threshold in bytes including FCS.
REQ-004 Port clk  in  1  single clock; all logic rising-edge.
REQ-005 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port rx_vld  in  1  beat valid; no backpressure, beat always consumed.
REQ-007 Port rx_data  in  64  beat data, byte 0 = [7:0] = first on wire.
REQ-008 Port rx_sof / rx_eof  in  1 each  first / last beat of frame; both may be high (single-beat frame).
REQ-009 Port rx_bvalid  in  8  byte enables, LSB-contiguous; only non-8'hFF on eof beat.
REQ-010 Port stat_pull  in  1  pop status head; ignored when empty.
REQ-011 Ports stat_dataout  out DW  head word (show-ahead); stat_empty / stat_full  out 1; stat_ovf  out 1  sticky overflow.

Function
REQ-012 CRC-32 reflected (poly 32'hEDB88320), init 32'hFFFFFFFF at sof, updated over valid bytes of every accepted beat including received FCS; no final inversion.
REQ-013 Status word: [31] crc_ok (residue == 32'hDEBB20E3), [30] runt (<64 bytes), [29] giant (>MAXLEN), [28] seq_err, [27:16] zero, [15:0] byte count incl. FCS, saturating at 16'hFFFF.
REQ-014 FSM states IDLE, FRAME. IDLE->FRAME on rx_vld&rx_sof&!rx_eof; FRAME->IDLE on rx_vld&rx_eof; sof&eof single beat stays IDLE and completes frame.
REQ-015 rx_vld without sof in IDLE: beat discarded, no status, no state change.
REQ-016 rx_sof in FRAME: current frame closed with seq_err=1, crc_ok=0, count so far; new frame started on same beat.
REQ-017 Status pushed exactly one cycle after eof beat (residue compare registered); stat_empty falls two cycles after eof beat.
REQ-018 Push when full and no same-cycle pull: word dropped, stat_ovf set until reset; push and pull same cycle when full: both succeed.
REQ-019 Pull and push same cycle when empty: push succeeds, pull ignored.
REQ-020 rx_bvalid non-contiguous on eof: bytes counted/hashed per set bits only, seq_err=1.

Reset
REQ-021 On rst_n low: FSM IDLE, CRC 32'hFFFFFFFF, count 0, FIFO pointers 0, stat_empty=1, stat_full=0, stat_ovf=0, stat_dataout=0.
REQ-022 Reset mid-frame: partial frame discarded, no status generated after release.

Configuration
REQ-023 Macro ETH_RX_LEN_CHK_EN defined: runt/giant bits computed per REQ-013.
REQ-024 Macro ETH_RX_LEN_CHK_EN undefined: bits [30:29] tied 0, comparator logic absent; all else identical.

Structure
REQ-025 Package eth_rx_pkg SHALL hold CRC poly, residue constant, min-length 64, FSM state enum, status-word struct.
REQ-026 Status FIFO SHALL be sub-module eth_rx_stat_fifo (AW, DW params; push/pull/full/empty); CRC byte-step as package function.

Verification
REQ-027 64-byte frame, 8 full beats, correct FCS -> one status 32'h8000_0040, stat_empty low at eof+2.
REQ-028 Same frame with byte 10 flipped -> 32'h0000_0040.
REQ-029 60-byte frame (eof bvalid 8'h0F), correct FCS, macro defined -> 32'hC000_003C; macro undefined -> 32'h8000_003C.
REQ-030 sof at beat 3 of open frame -> first status 32'h1000_0018, second frame status normal.
REQ-031 2**AW+1 good frames, no pulls -> stat_full=1, stat_ovf=1, first 2**AW words intact on drain.
REQ-032 rst_n low during beat 4 of a frame, release, send good frame -> exactly one status 32'h8000_0040.
